// File: rtl/gpio_pkg.sv
// gpio_pkg: AVR-style register offsets, GPIO base address and word-address helper
package gpio_pkg;

   localparam logic [31:0] GPIO_BASE   = 32'h1000_0000;

   localparam logic [7:0]  GPIOB_PINB  = 8'h23;
   localparam logic [7:0]  GPIOB_DDRB  = 8'h24;
   localparam logic [7:0]  GPIOB_PORTB = 8'h25;
   localparam logic [7:0]  GPIOC_PINC  = 8'h26;
   localparam logic [7:0]  GPIOC_DDRC  = 8'h27;
   localparam logic [7:0]  GPIOC_PORTC = 8'h28;
   localparam logic [7:0]  GPIOD_PIND  = 8'h29;
   localparam logic [7:0]  GPIOD_DDRD  = 8'h2A;
   localparam logic [7:0]  GPIOD_PORTD = 8'h2B;

   // Word address (byte address >> 2) of a register at base + offset
   function automatic logic [29:0] word_of(input logic [31:0] base, input logic [7:0] off);
      return 30'((base + 32'(off)) >> 2);
   endfunction

endpackage

// File: rtl/gpio_port.sv
// gpio_port: one 8-bit port with DDR/PORT registers and a 2-flop pad synchronizer
module gpio_port
   import gpio_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ddr_we_i,
   input  logic [7:0] ddr_d_i,
   input  logic       port_we_i,
   input  logic [7:0] port_d_i,
   input  logic [7:0] pad_i,
   output logic [7:0] pin_o,
   output logic [7:0] ddr_o,
   output logic [7:0] port_o
);

   logic [7:0] ddr_q, ddr_d, port_q, port_d, sync1_q, sync2_q;

   // Byte-enabled next state for the direction and output registers
   always_comb begin
      ddr_d  = ddr_we_i  ? ddr_d_i  : ddr_q;
      port_d = port_we_i ? port_d_i : port_q;
   end

   // Register state; pads are asynchronous so they pass through two flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ddr_q   <= 8'h00;
         port_q  <= 8'h00;
         sync1_q <= 8'h00;
         sync2_q <= 8'h00;
      end else begin
         ddr_q   <= ddr_d;
         port_q  <= port_d;
         sync1_q <= pad_i;
         sync2_q <= sync1_q;
      end
   end

   assign pin_o  = sync2_q;
   assign ddr_o  = ddr_q;
   assign port_o = port_q;

endmodule

// File: rtl/gpio.sv
// gpio: bus slave decoding three AVR-style GPIO ports (B, C, D) onto a 32-bit word bus
module gpio
   import gpio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = GPIO_BASE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   input  logic [7:0]  gpio_pin_in_b,
   output logic [7:0]  gpio_pin_out_b,
   output logic [7:0]  gpio_pin_dir_b,
   input  logic [7:0]  gpio_pin_in_c,
   output logic [7:0]  gpio_pin_out_c,
   output logic [7:0]  gpio_pin_dir_c,
   input  logic [7:0]  gpio_pin_in_d,
   output logic [7:0]  gpio_pin_out_d,
   output logic [7:0]  gpio_pin_dir_d
);

   logic       hit0, hit1, hit2, wr, unused_addr;
   logic [7:0] pin_b, ddr_b, port_b, pin_c, ddr_c, port_c, pin_d, ddr_d, port_d;

   assign unused_addr = ^mem_addr[1:0];

   // Word 0x20 holds PINB, 0x24 DDRB..DDRC, 0x28 PORTC..PORTD
   assign hit0      = mem_addr[31:2] == word_of(BASE_ADDR, GPIOB_PINB);
   assign hit1      = mem_addr[31:2] == word_of(BASE_ADDR, GPIOB_DDRB);
   assign hit2      = mem_addr[31:2] == word_of(BASE_ADDR, GPIOC_PORTC);
   assign mem_ready = mem_valid && (hit0 || hit1 || hit2);
   assign wr        = mem_ready;

   gpio_port u_port_b (
      .clk, .rst_n,
      .ddr_we_i  (wr && hit1 && mem_wstrb[0]), .ddr_d_i  (mem_wdata[7:0]),
      .port_we_i (wr && hit1 && mem_wstrb[1]), .port_d_i (mem_wdata[15:8]),
      .pad_i     (gpio_pin_in_b), .pin_o (pin_b), .ddr_o (ddr_b), .port_o (port_b)
   );

   gpio_port u_port_c (
      .clk, .rst_n,
      .ddr_we_i  (wr && hit1 && mem_wstrb[3]), .ddr_d_i  (mem_wdata[31:24]),
      .port_we_i (wr && hit2 && mem_wstrb[0]), .port_d_i (mem_wdata[7:0]),
      .pad_i     (gpio_pin_in_c), .pin_o (pin_c), .ddr_o (ddr_c), .port_o (port_c)
   );

   gpio_port u_port_d (
      .clk, .rst_n,
      .ddr_we_i  (wr && hit2 && mem_wstrb[2]), .ddr_d_i  (mem_wdata[23:16]),
      .port_we_i (wr && hit2 && mem_wstrb[3]), .port_d_i (mem_wdata[31:24]),
      .pad_i     (gpio_pin_in_d), .pin_o (pin_d), .ddr_o (ddr_d), .port_o (port_d)
   );

   // Lane mux; PINx lanes are read-only and unmapped lanes or misses read zero
   always_comb begin
      mem_rdata = hit0 ? {pin_b, 24'h0} :
                  hit1 ? {ddr_c, pin_c, port_b, ddr_b} :
                  hit2 ? {port_d, ddr_d, pin_d, port_c} : 32'h0;
   end

   assign gpio_pin_out_b = port_b;
   assign gpio_pin_dir_b = ddr_b;
   assign gpio_pin_out_c = port_c;
   assign gpio_pin_dir_c = ddr_c;
   assign gpio_pin_out_d = port_d;
   assign gpio_pin_dir_d = ddr_d;

endmodule

// File: tb/tb_gpio.sv
// tb_gpio: scoreboard bench for the GPIO block with directed bus and pad vectors
module tb_gpio;

   localparam logic [31:0] W20 = 32'h1000_0020;
   localparam logic [31:0] W24 = 32'h1000_0024;
   localparam logic [31:0] W28 = 32'h1000_0028;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [3:0]  mem_wstrb = 4'h0;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [7:0]  in_b = 8'h00, in_c = 8'h00, in_d = 8'h00;
   logic [7:0]  out_b, dir_b, out_c, dir_c, out_d, dir_d;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   gpio dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_valid      (mem_valid),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wstrb      (mem_wstrb),
      .mem_rdata      (mem_rdata),
      .mem_ready      (mem_ready),
      .gpio_pin_in_b  (in_b),
      .gpio_pin_out_b (out_b),
      .gpio_pin_dir_b (dir_b),
      .gpio_pin_in_c  (in_c),
      .gpio_pin_out_c (out_c),
      .gpio_pin_dir_c (dir_c),
      .gpio_pin_in_d  (in_d),
      .gpio_pin_out_d (out_d),
      .gpio_pin_dir_d (dir_d)
   );

   always #5 clk = ~clk;

   // Monitor: each acknowledged read pops the oldest expectation
   always @(negedge clk) begin
      if (mem_valid && mem_ready && mem_wstrb == 4'h0 && sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_cmp++;
         if (mem_rdata !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", e.name, mem_rdata, e.exp);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(posedge clk);
      #1;
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = d;
      mem_wstrb = s;
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
      int n;
      exp_t e;
      n = sb.size();
      e.exp  = exp;
      e.name = nm;
      @(posedge clk);
      #1;
      sb.push_back(e);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wstrb = 4'h0;
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      if (sb.size() > n) begin
         void'(sb.pop_back());
         n_cmp++;
         n_bad++;
         $display("FAIL %s: no mem_ready response, expected %08h", nm, exp);
      end
   endtask

   initial begin
      cycles(3);
      @(negedge clk);
      rst_n = 1'b1;
      // Reset state
      bus_read(W24, 32'h0000_0000, "reset_w24");
      bus_read(W28, 32'h0000_0000, "reset_w28");
      chk("reset_dir", {8'h0, dir_b, dir_c, dir_d}, 32'h0);
      chk("reset_out", {8'h0, out_b, out_c, out_d}, 32'h0);
      // Pad sampling on port C
      in_c = 8'hAA;
      cycles(3);
      bus_read(W24, 32'h00AA_0000, "pinc_aa");
      // DDRC then PORTC writes
      bus_write(W24, 32'hFF00_0000, 4'b1000);
      bus_write(W28, 32'h0000_0055, 4'b0001);
      bus_read(W24, 32'hFFAA_0000, "ddrc_ff");
      bus_read(W28, 32'h0000_0055, "portc_55");
      chk("dir_c_ff", {24'h0, dir_c}, 32'hFF);
      chk("out_c_55", {24'h0, out_c}, 32'h55);
      bus_write(W28, 32'h0000_00AA, 4'b0001);
      bus_read(W28, 32'h0000_00AA, "portc_aa");
      chk("out_c_aa", {24'h0, out_c}, 32'hAA);
      // DDRC 0x0F with pads 0xF0
      in_c = 8'hF0;
      bus_write(W24, 32'h0F00_0000, 4'b1000);
      cycles(3);
      bus_read(W24, 32'h0FF0_0000, "ddrc_0f_pinc_f0");
      bus_read(W28, 32'h0000_00AA, "ddrd_still_0");
      chk("dir_c_0f", {24'h0, dir_c}, 32'h0F);
      chk("dir_bd_0", {16'h0, dir_b, dir_d}, 32'h0);
      // PINC is read-only
      bus_write(W24, 32'h00FF_0000, 4'b0100);
      in_c = 8'h33;
      cycles(3);
      bus_read(W24, 32'h0F33_0000, "pinc_ro_33");
      bus_read(W28, 32'h0000_00AA, "portc_kept");
      // Multi-lane write
      bus_write(W24, 32'h1122_3344, 4'b1111);
      bus_read(W24, 32'h1133_3344, "multilane");
      chk("multi_outs", {dir_b, out_b, dir_c, out_c}, 32'h4433_11AA);
      // Ports B and D pads, then DDRD/PORTD
      in_b = 8'h5A;
      in_d = 8'hC3;
      cycles(3);
      bus_read(W20, 32'h5A00_0000, "pinb_5a");
      bus_read(W28, 32'h0000_C3AA, "pind_c3");
      bus_write(W28, 32'hBE7E_0000, 4'b1100);
      bus_read(W28, 32'hBE7E_C3AA, "ddrd_portd");
      chk("port_d_outs", {16'h0, dir_d, out_d}, 32'h7EBE);
      chk("port_b_kept", {16'h0, dir_b, out_b}, 32'h4433);
      // Miss: no ready, zero data, no write side-effect
      @(posedge clk);
      #1;
      mem_valid = 1'b1;
      mem_addr  = 32'h1000_0040;
      mem_wstrb = 4'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("miss_ready", {31'h0, mem_ready}, 32'h0);
      end
      chk("miss_rdata", mem_rdata, 32'h0);
      mem_valid = 1'b0;
      bus_write(32'h1000_0044, 32'hFFFF_FFFF, 4'b1111);
      bus_read(W24, 32'h1133_3344, "miss_write_ignored");
      // Async reset clears registers and synchronizers
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_dir", {8'h0, dir_b, dir_c, dir_d}, 32'h0);
      chk("rst_out", {8'h0, out_b, out_c, out_d}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(3);
      bus_read(W24, 32'h0033_0000, "post_reset_w24");
      bus_read(W28, 32'h0000_C300, "post_reset_w28");
      cycles(2);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
